imem_boot_loader: RTL and testbench

//   Loads a program into instruction memory from a byte stream (UART RX or a bench) before the core runs.

---
 rtl/imem_boot_loader.sv | 167 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed little-endian image into IMEM and holds the core in reset until done.
// Optional `CHECKSUM_EN adds a trailing XOR byte check (CHK state) before the core is released.
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              boot_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {HDR0, HDR1, DATA, CHK, RUN, ERR} state_t;
    localparam state_t END_ST = CHK;
`else
    typedef enum logic [2:0] {HDR0, HDR1, DATA, RUN, ERR} state_t;
    localparam state_t END_ST = RUN;
`endif

    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [7:0]        cnt_lo_q, cnt_lo_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   widx_q, widx_d, widx_nxt;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       wbuf_q, wbuf_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       hdr_count;
    logic              xfer;
`ifdef CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    assign rx_ready  = !boot_req && (state_q != RUN) && (state_q != ERR);
    assign xfer      = rx_valid && rx_ready;
    assign hdr_count = {rx_data, cnt_lo_q};
    // One extra bit so a full-capacity image can count past the last address.
    assign widx_nxt  = widx_q + (ADDR_W + 1)'(1);

    always_comb begin
        state_d      = state_q;
        cnt_lo_d     = cnt_lo_q;
        count_d      = count_q;
        widx_d       = widx_q;
        lane_d       = lane_q;
        wbuf_d       = wbuf_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        // Status lags the state by one cycle so release follows the final write pulse.
        core_rst_d   = (state_q != RUN);
        done_d       = (state_q == RUN);
        err_d        = (state_q == ERR);
`ifdef CHECKSUM_EN
        xor_d        = xor_q;
`endif
        if (boot_req) begin
            state_d    = HDR0;
            cnt_lo_d   = 8'd0;
            count_d    = '0;
            widx_d     = '0;
            lane_d     = 2'd0;
            wbuf_d     = 24'd0;
            core_rst_d = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
`ifdef CHECKSUM_EN
            xor_d      = 8'd0;
`endif
        end else if (xfer) begin
`ifdef CHECKSUM_EN
            if (state_q != CHK) xor_d = xor_q ^ rx_data;
`endif
            case (state_q)
                HDR0: begin
                    cnt_lo_d = rx_data;
                    state_d  = HDR1;
                end
                HDR1: begin
                    count_d = hdr_count[ADDR_W:0];
                    widx_d  = '0;
                    lane_d  = 2'd0;
                    if ({1'b0, hdr_count} > CAP) state_d = ERR;
                    else if (hdr_count == 16'd0) state_d = END_ST;
                    else state_d = DATA;
                end
                DATA: begin
                    case (lane_q)
                        2'd0: wbuf_d[7:0]   = rx_data;
                        2'd1: wbuf_d[15:8]  = rx_data;
                        2'd2: wbuf_d[23:16] = rx_data;
                        default: begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = widx_q[ADDR_W-1:0];
                            imem_wdata_d = {rx_data, wbuf_q};
                            widx_d       = widx_nxt;
                            if (widx_nxt == count_q) state_d = END_ST;
                        end
                    endcase
                    lane_d = lane_q + 2'd1;
                end
`ifdef CHECKSUM_EN
                CHK: state_d = (rx_data == xor_q) ? RUN : ERR;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HDR0;
            cnt_lo_q     <= 8'd0;
            count_q      <= '0;
            widx_q       <= '0;
            lane_q       <= 2'd0;
            wbuf_q       <= 24'd0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef CHECKSUM_EN
            xor_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_lo_q     <= cnt_lo_d;
            count_q      <= count_d;
            widx_q       <= widx_d;
            lane_q       <= lane_d;
            wbuf_q       <= wbuf_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef CHECKSUM_EN
            xor_q        <= xor_d;
`endif
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: image loads, empty/oversize headers, rx gaps, boot_req restart, async reset.
module tb_imem_boot_loader;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              boot_req;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              done;
    logic              err;

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .boot_req(boot_req), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_we_cyc = -1;
    int done_cyc = -1;
    int rel_cyc = -1;
    logic done_prev = 1'b0;
    logic core_rst_prev = 1'b1;
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    logic [7:0]        img_xor;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            last_we_cyc = cyc;
        end
        if (done && !done_prev) done_cyc = cyc;
        if (!core_rst && core_rst_prev) rel_cyc = cyc;
        done_prev = done;
        core_rst_prev = core_rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // All drive tasks start and end at 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        rx_data = b;
        rx_valid = 1'b1;
        img_xor = img_xor ^ b;
        n = 0;
        @(negedge clk);
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; failures++;
            $display("FAIL send_byte_timeout: rx_ready got 0 want 1 for byte %h", b);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_image(input int cnt, input logic [31:0] w0, input logic [31:0] w1, input bit gap);
        logic [31:0] w;
        logic [7:0]  c;
        img_xor = 8'h00;
        send_byte(cnt[7:0], gap);
        send_byte(cnt[15:8], gap);
        for (int i = 0; i < cnt; i++) begin
            w = (i == 0) ? w0 : w1;
            for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
        end
`ifdef CHECKSUM_EN
        c = img_xor;
        send_byte(c, gap);
`else
        c = 8'h00;
`endif
    endtask

    task automatic pulse_boot();
        boot_req = 1'b1;
        @(posedge clk); #1;
        boot_req = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        done_cyc = -1;
        rel_cyc = -1;
        last_we_cyc = -1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; boot_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL reset_imem_we: got %b want 0", imem_we); end
        checks++; if (imem_addr !== '0) begin failures++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
        checks++; if (imem_wdata !== 32'h0) begin failures++; $display("FAIL reset_imem_wdata: got %h want 0", imem_wdata); end
        checks++; if (core_rst !== 1'b1) begin failures++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_two_words(input string tag);
        checks++; if (wr_addr.size() !== 2) begin failures++; $display("FAIL %s_write_count: got %0d want 2", tag, wr_addr.size()); end
        if (wr_addr.size() == 2) begin
            checks++; if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h00500013) begin failures++; $display("FAIL %s_word0: got addr %h data %h want addr 00 data 00500013", tag, wr_addr[0], wr_data[0]); end
            checks++; if (wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h00100093) begin failures++; $display("FAIL %s_word1: got addr %h data %h want addr 01 data 00100093", tag, wr_addr[1], wr_data[1]); end
        end
        checks++; if (done !== 1'b1 || core_rst !== 1'b0) begin failures++; $display("FAIL %s_release: got done %b core_rst %b want done 1 core_rst 0", tag, done, core_rst); end
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL %s_rx_ready_run: got %b want 0", tag, rx_ready); end
    endtask

    task automatic test_two_words();
        wr_addr.delete(); wr_data.delete();
        send_image(2, 32'h00500013, 32'h00100093, 1'b0);
        wait_cycles(3);
        @(negedge clk);
        check_two_words("two_words");
        checks++; if (rel_cyc !== done_cyc) begin failures++; $display("FAIL release_align: core_rst fall cycle %0d want done rise cycle %0d", rel_cyc, done_cyc); end
`ifndef CHECKSUM_EN
        checks++; if (done_cyc !== last_we_cyc + 1) begin failures++; $display("FAIL release_timing: done rise cycle %0d want %0d", done_cyc, last_we_cyc + 1); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        wr_addr.delete(); wr_data.delete();
        pulse_boot();
        img_xor = 8'h00;
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (imem_wdata !== 32'h0 || imem_addr !== '0) begin failures++; $display("FAIL async_rst_data: got addr %h data %h want 0 0", imem_addr, imem_wdata); end
        checks++; if (core_rst !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b1) begin failures++; $display("FAIL async_rst_ctrl: got core_rst %b done %b rx_ready %b want 1 0 1", core_rst, done, rx_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        wr_addr.delete(); wr_data.delete();
        send_image(1, 32'h0BADF00D, 32'h0, 1'b0);
        wait_cycles(3);
        @(negedge clk);
        checks++; if (wr_addr.size() !== 1) begin failures++; $display("FAIL async_reload_count: got %0d want 1", wr_addr.size()); end
        else begin
            checks++; if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h0BADF00D) begin failures++; $display("FAIL async_reload_word: got addr %h data %h want 00 0badf00d", wr_addr[0], wr_data[0]); end
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL async_reload_done: got %b want 1", done); end
        @(posedge clk); #1;
    endtask

    task automatic test_empty();
        pulse_boot();
        send_image(0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL empty_rx_ready: got %b want 0", rx_ready); end
        wait_cycles(2);
        @(negedge clk);
        checks++; if (done !== 1'b1 || core_rst !== 1'b0) begin failures++; $display("FAIL empty_release: got done %b core_rst %b want 1 0", done, core_rst); end
        checks++; if (wr_addr.size() !== 0) begin failures++; $display("FAIL empty_writes: got %0d want 0", wr_addr.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_too_big();
        pulse_boot();
        img_xor = 8'h00;
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        @(negedge clk);
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL big_rx_ready: got %b want 0", rx_ready); end
        wait_cycles(3);
        @(negedge clk);
        checks++; if (err !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL big_err_state: got err %b core_rst %b done %b want 1 1 0", err, core_rst, done); end
        checks++; if (wr_addr.size() !== 0) begin failures++; $display("FAIL big_writes: got %0d want 0", wr_addr.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_gapped();
        pulse_boot();
        send_image(2, 32'h00500013, 32'h00100093, 1'b1);
        wait_cycles(3);
        @(negedge clk);
        check_two_words("gapped");
        @(posedge clk); #1;
    endtask

    task automatic test_boot_req_mid();
        pulse_boot();
        @(negedge clk);
        checks++; if (err !== 1'b0 || core_rst !== 1'b1) begin failures++; $display("FAIL boot_clears_err: got err %b core_rst %b want 0 1", err, core_rst); end
        @(posedge clk); #1;
        img_xor = 8'h00;
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        rx_data = 8'h55; rx_valid = 1'b1; boot_req = 1'b1;
        @(negedge clk);
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL boot_rx_ready: got %b want 0", rx_ready); end
        checks++; if (imem_we !== 1'b1 || imem_wdata !== 32'h44332211) begin failures++; $display("FAIL boot_pending_write: got we %b data %h want 1 44332211", imem_we, imem_wdata); end
        @(posedge clk); #1;
        boot_req = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        checks++; if (core_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0 || rx_ready !== 1'b1) begin failures++; $display("FAIL boot_restart: got core_rst %b done %b err %b rx_ready %b want 1 0 0 1", core_rst, done, err, rx_ready); end
        @(posedge clk); #1;
        wr_addr.delete(); wr_data.delete();
        send_image(1, 32'hAABBCCDD, 32'h0, 1'b0);
        wait_cycles(3);
        @(negedge clk);
        checks++; if (wr_addr.size() !== 1) begin failures++; $display("FAIL boot_reload_count: got %0d want 1", wr_addr.size()); end
        else begin
            checks++; if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'hAABBCCDD) begin failures++; $display("FAIL boot_reload_word: got addr %h data %h want 00 aabbccdd", wr_addr[0], wr_data[0]); end
        end
        checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL boot_reload_done: got done %b err %b want 1 0", done, err); end
        @(posedge clk); #1;
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] img[7];
        img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        pulse_boot();
        foreach (img[i]) send_byte(img[i], 1'b0);
        wait_cycles(2);
        @(negedge clk);
        checks++; if (done !== 1'b1 || err !== 1'b0 || core_rst !== 1'b0) begin failures++; $display("FAIL chk_good: got done %b err %b core_rst %b want 1 0 0", done, err, core_rst); end
        @(posedge clk); #1;
        img[6] = 8'h46;
        pulse_boot();
        foreach (img[i]) send_byte(img[i], 1'b0);
        wait_cycles(2);
        @(negedge clk);
        checks++; if (err !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL chk_bad: got err %b core_rst %b done %b want 1 1 0", err, core_rst, done); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_two_words();
        test_async_reset();
        test_empty();
        test_too_big();
        test_boot_req_mid();
        test_gapped();
`ifdef CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
